// File: rtl/word_byte_serializer.sv
// Serializes a 1/2/4-byte field of a 32-bit word MSB-first onto a byte valid/ready port.
// First byte is valid the cycle after Load is taken; OReady low holds O/Last stable, Done pulses after the final beat.
module word_byte_serializer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] word_i,
    input  logic        oready_i,
    output logic        busy_o,
    output logic [7:0]  o_o,
    output logic        ovalid_o,
    output logic        last_o,
    output logic        done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sr_q    <= 32'h0;
            cnt_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    // Left-justify the selected field so the outgoing byte is always sr[31:24].
                    case (size_i)
                        2'b00: begin
                            sr_d  = {word_i[7:0], 24'h0};
                            cnt_d = 2'd0;
                        end
                        2'b01: begin
                            sr_d  = {word_i[15:0], 16'h0};
                            cnt_d = 2'd1;
                        end
                        default: begin
                            sr_d  = word_i;
                            cnt_d = 2'd3;
                        end
                    endcase
                    state_d = SEND;
                end
            end
            SEND: begin
                if (oready_i) begin
                    if (cnt_q != 2'd0) begin
                        sr_d  = {sr_q[23:0], 8'h00};
                        cnt_d = cnt_q - 2'd1;
                    end else begin
                        sr_d    = 32'h0;
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sr is cleared whenever the FSM returns to IDLE, so O reads 00 there.
    assign o_o      = sr_q[31:24];
    assign ovalid_o = (state_q == SEND);
    assign busy_o   = (state_q == SEND);
    assign last_o   = (state_q == SEND) && (cnt_q == 2'd0);
    assign done_o   = done_q;

endmodule

// File: doc/word_byte_serializer.md
# word_byte_serializer

Byte-stream transmitter for 32-bit register words: accepts a word with a size code, then emits its bytes most-significant-first over an 8-bit valid/ready interface. It is the outbound counterpart of the byte-assembling register path, where each incoming byte enters at the low end and earlier bytes move toward the MSB. It sits between the register file/ALU output and any byte-wide sink, such as a memory port or a link.

## Interface
- no parameters; word width is fixed at 32 bits (4 bytes), byte width at 8 bits
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low; sampled on rising edge of Clock
- Load  in  1  request to capture I and Size; honoured only when Busy=0
- Size  in  2  bytes to send: 00=1 (I[7:0]), 01=2 (I[15:0]), 10=4 (I[31:0]), 11=reserved, treated as 10
- I  in  32  word to serialize
- Busy  out  1  high while a word is being sent; Load is ignored while high
- O  out  8  current byte
- OValid  out  1  O holds a valid byte
- OReady  in  1  sink accepts O on a cycle where OValid&OReady (a "beat")
- Last  out  1  high with the final byte of the word (OValid&&count==0)
- Done  out  1  one-cycle pulse after the final beat

## Operation
- Internal state:
  - 32-bit shift register SR
  - 2-bit remaining-count CNT
  - FSM states IDLE and SEND
- Reset (Reset=0 at an edge): state IDLE, SR=0, CNT=0, Busy=0, OValid=0, O=8'h00, Last=0, Done=0. Reset has priority over all other inputs.
- IDLE, Load=1: capture I left-justified so the first byte sent is the most significant byte of the selected field.
  - Size 00: SR={I[7:0],24'h0}, CNT=0
  - Size 01: SR={I[15:0],16'h0}, CNT=1
  - Size 10/11: SR=I, CNT=3
  - Then go to SEND.
- SEND outputs:
  - O=SR[31:24], OValid=1, Busy=1, Last=(CNT==0).
- SEND, beat with CNT!=0: SR<=SR<<8 (zero fill), CNT<=CNT-1, stay in SEND.
- SEND, beat with CNT==0: SR<=0, CNT<=0, state IDLE, Done<=1 for exactly the next cycle.
- SEND, no beat: SR, CNT, O, Last held stable. O must not change while OValid&&!OReady.
- Load while Busy=1: ignored; no effect on SR, CNT or outputs.
- Done is 0 at all other times.
- In IDLE: O=SR[31:24]=8'h00, OValid=0, Last=0.
- Bytes not selected by Size never appear on O.

## Timing
- Load sampled high at edge k (IDLE): OValid=1 and first byte on O from edge k onward. The first beat can occur in the cycle after edge k.
- With OReady held high, an N-byte word (N=1,2,4) takes N consecutive beat cycles. Busy falls and Done pulses at the edge closing the last beat.
- Back-to-back words:
  - Load may be asserted in the Done cycle (state IDLE) and is accepted at the next edge.
  - Minimum spacing is 1 idle cycle between words, giving throughput N bytes per N+1 cycles.
- Backpressure: any number of OReady=0 cycles between beats is allowed, with no byte loss or duplication.
- Reset mid-word:
  - Next edge forces the reset values; remaining bytes are discarded.
  - No Done pulse is produced.
  - Next Load after reset release behaves normally.
- Reset asserted together with Load or a beat: reset wins, and the word is not captured.
- All outputs are registered or decoded from registered state only. There is no combinational path from OReady or Load to O, OValid or Last.

## Test plan
- Reset: hold Reset=0 for 2 cycles with Load=1, I=32'hFFFFFFFF -> O=00, OValid=0, Busy=0, Last=0, Done=0. No capture occurs.
- Full word: Size=10, I=32'hA1B2C3D4, Load pulse, OReady=1 -> O=A1,B2,C3,D4 on 4 consecutive cycles with Last only on D4. Done pulses one cycle later, then Busy=0.
- Partial sizes:
  - Size=01, I=32'h1234BEEF -> BE then EF (Last on EF).
  - Size=00, I=32'hFFFFFF5A -> single 5A with Last=1.
  - Size=11, I=32'h01020304 -> 01,02,03,04.
- Backpressure and ignored load: Size=10, I=32'hCAFEF00D, OReady pattern 1,0,0,1,0,1,1.
  - O holds each byte while OReady=0.
  - Output sequence is CA,FE,F0,0D.
  - Load=1 with I=32'hDEADBEEF mid-word changes nothing.
- Back-to-back: Load word 32'h11223344 (Size=10), then Load 32'h000055AA (Size=01) in the Done cycle -> 11,22,33,44, then one idle cycle, then 55,AA. There are exactly two Done pulses.
- Reset mid-word: Size=10, I=32'hA1B2C3D4; after 2 beats drive Reset=0 for 1 cycle -> OValid=0, O=00 next cycle, no Done. A following Load of 32'h00000077 with Size=00 emits 77 with Last.
